// File: rtl/mem_access_unit_if.sv
// ============================================================================
//  Module      : mem_access_unit_if
//  Description : Command, status and RAM-port bundle for mem_access_unit.
//                The slave modport is the unit itself. The master modport is
//                the control unit and RAM side that surrounds it.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_access_unit_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  // command channel
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [ADDR_W-1:0] cmd_src;
  logic [7:0]        cmd_len;
  logic [DATA_W-1:0] cmd_wdata;

  // completion status
  logic              done;
  logic [DATA_W-1:0] rd_data;
  logic              wrap_err;

  // RAM port (combinational read data)
  logic              ram_we;
  logic              ram_re;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_src, cmd_len, cmd_wdata, ram_rdata,
    output cmd_ready, done, rd_data, wrap_err, ram_we, ram_re, ram_addr, ram_wdata
  );

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_src, cmd_len, cmd_wdata, ram_rdata,
    input  cmd_ready, done, rd_data, wrap_err, ram_we, ram_re, ram_addr, ram_wdata
  );
endinterface

`default_nettype wire

// File: rtl/mem_access_unit.sv
// ============================================================================
//  Module      : mem_access_unit
//  Description : Executes LOAD / STORE / FILL / COPY commands against a
//                single-port RAM with combinational read data. Every output
//                is a register loaded from the next-state logic. RAM strobes
//                therefore appear in the cycle after the decision is made.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_unit #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  mem_access_unit_if.slave   bus
);

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_STORE = 2'b01;
  localparam logic [1:0] OP_FILL  = 2'b10;

  // Wide enough to hold start + len - 1 without losing the carry.
  localparam int EXT_W = ADDR_W + 9;
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LD_RD   = 3'd1,
    ST_WR   = 3'd2,
    FILL_WR = 3'd3,
    CP_RD   = 3'd4,
    CP_WR   = 3'd5,
    DONE    = 3'd6
  } state_t;

  // True when a burst of len words from start runs past the top address.
  // This is decided once at acceptance, so the walk itself needs no
  // carry tracking. Only called with len > 0.
  function automatic logic span_wraps(input logic [ADDR_W-1:0] start,
                                      input logic [7:0]        len);
    logic [EXT_W-1:0] last;
    last = EXT_W'(start) + EXT_W'(len) - EXT_W'(1);
    return last > EXT_W'(ADDR_MAX);
  endfunction

  state_t            state, state_nx;

  // working copies of the accepted command
  logic [ADDR_W-1:0] dst, dst_nx;
  logic [ADDR_W-1:0] src, src_nx;
  logic [7:0]        remain, remain_nx;
  logic [DATA_W-1:0] fill, fill_nx;
  logic              wrap, wrap_nx;

  // registered outputs and their next values
  logic              cmd_ready_reg, cmd_ready_nx;
  logic              done_reg, done_nx;
  logic              wrap_err_reg, wrap_err_nx;
  logic [DATA_W-1:0] rd_data_reg, rd_data_nx;
  logic              ram_we_reg, ram_we_nx;
  logic              ram_re_reg, ram_re_nx;
  logic [ADDR_W-1:0] ram_addr_reg, ram_addr_nx;
  logic [DATA_W-1:0] ram_wdata_reg, ram_wdata_nx;

  // Next-state decode and next values of every registered output.
  // remain counts the RAM words still to be written after the one being
  // issued now. A FILL writes in every cycle. A COPY spends a read cycle
  // and then a write cycle on each word.
  always_comb begin
    state_nx     = state;
    dst_nx       = dst;
    src_nx       = src;
    remain_nx    = remain;
    fill_nx      = fill;
    wrap_nx      = wrap;
    cmd_ready_nx = 1'b0;
    done_nx      = 1'b0;
    wrap_err_nx  = 1'b0;
    rd_data_nx   = rd_data_reg;
    ram_we_nx    = 1'b0;
    ram_re_nx    = 1'b0;
    ram_addr_nx  = '0;
    ram_wdata_nx = '0;

    case (state)
      IDLE: begin
        cmd_ready_nx = 1'b1;
        if (bus.cmd_valid) begin
          cmd_ready_nx = 1'b0;
          dst_nx       = bus.cmd_addr;
          src_nx       = bus.cmd_src;
          remain_nx    = bus.cmd_len;
          fill_nx      = bus.cmd_wdata;
          wrap_nx      = 1'b0;
          case (bus.cmd_op)
            OP_LOAD: begin
              state_nx    = LD_RD;
              ram_re_nx   = 1'b1;
              ram_addr_nx = bus.cmd_addr;
            end
            OP_STORE: begin
              state_nx     = ST_WR;
              ram_we_nx    = 1'b1;
              ram_addr_nx  = bus.cmd_addr;
              ram_wdata_nx = bus.cmd_wdata;
            end
            OP_FILL: begin
              if (bus.cmd_len == 8'd0) begin
                state_nx = DONE;
                done_nx  = 1'b1;
              end else begin
                state_nx     = FILL_WR;
                ram_we_nx    = 1'b1;
                ram_addr_nx  = bus.cmd_addr;
                ram_wdata_nx = bus.cmd_wdata;
                dst_nx       = bus.cmd_addr + ADDR_ONE;
                remain_nx    = bus.cmd_len - 8'd1;
                wrap_nx      = span_wraps(bus.cmd_addr, bus.cmd_len);
              end
            end
            default: begin  // COPY
              if (bus.cmd_len == 8'd0) begin
                state_nx = DONE;
                done_nx  = 1'b1;
              end else begin
                state_nx    = CP_RD;
                ram_re_nx   = 1'b1;
                ram_addr_nx = bus.cmd_src;
                src_nx      = bus.cmd_src + ADDR_ONE;
                wrap_nx     = span_wraps(bus.cmd_addr, bus.cmd_len) |
                              span_wraps(bus.cmd_src, bus.cmd_len);
              end
            end
          endcase
        end
      end

      LD_RD: begin
        rd_data_nx = bus.ram_rdata;
        state_nx   = DONE;
        done_nx    = 1'b1;
      end

      ST_WR: begin
        state_nx = DONE;
        done_nx  = 1'b1;
      end

      FILL_WR: begin
        if (remain == 8'd0) begin
          state_nx    = DONE;
          done_nx     = 1'b1;
          wrap_err_nx = wrap;
        end else begin
          ram_we_nx    = 1'b1;
          ram_addr_nx  = dst;
          ram_wdata_nx = fill;
          dst_nx       = dst + ADDR_ONE;
          remain_nx    = remain - 8'd1;
        end
      end

      // Read data is live this cycle, so it becomes the next write data.
      CP_RD: begin
        state_nx     = CP_WR;
        ram_we_nx    = 1'b1;
        ram_addr_nx  = dst;
        ram_wdata_nx = bus.ram_rdata;
        dst_nx       = dst + ADDR_ONE;
        remain_nx    = remain - 8'd1;
      end

      CP_WR: begin
        if (remain == 8'd0) begin
          state_nx    = DONE;
          done_nx     = 1'b1;
          wrap_err_nx = wrap;
        end else begin
          state_nx    = CP_RD;
          ram_re_nx   = 1'b1;
          ram_addr_nx = src;
          src_nx      = src + ADDR_ONE;
        end
      end

      DONE: begin
        state_nx     = IDLE;
        cmd_ready_nx = 1'b1;
      end

      default: begin
        state_nx     = IDLE;
        cmd_ready_nx = 1'b1;
      end
    endcase
  end

  // State and working registers. Reset abandons any command in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      dst    <= '0;
      src    <= '0;
      remain <= '0;
      fill   <= '0;
      wrap   <= 1'b0;
    end else begin
      state  <= state_nx;
      dst    <= dst_nx;
      src    <= src_nx;
      remain <= remain_nx;
      fill   <= fill_nx;
      wrap   <= wrap_nx;
    end
  end

  // Output registers. Reset clears RAM strobes immediately, so a write
  // pending in the current cycle is never committed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_ready_reg <= 1'b1;
      done_reg      <= 1'b0;
      wrap_err_reg  <= 1'b0;
      rd_data_reg   <= '0;
      ram_we_reg    <= 1'b0;
      ram_re_reg    <= 1'b0;
      ram_addr_reg  <= '0;
      ram_wdata_reg <= '0;
    end else begin
      cmd_ready_reg <= cmd_ready_nx;
      done_reg      <= done_nx;
      wrap_err_reg  <= wrap_err_nx;
      rd_data_reg   <= rd_data_nx;
      ram_we_reg    <= ram_we_nx;
      ram_re_reg    <= ram_re_nx;
      ram_addr_reg  <= ram_addr_nx;
      ram_wdata_reg <= ram_wdata_nx;
    end
  end

  assign bus.cmd_ready = cmd_ready_reg;
  assign bus.done      = done_reg;
  assign bus.wrap_err  = wrap_err_reg;
  assign bus.rd_data   = rd_data_reg;
  assign bus.ram_we    = ram_we_reg;
  assign bus.ram_re    = ram_re_reg;
  assign bus.ram_addr  = ram_addr_reg;
  assign bus.ram_wdata = ram_wdata_reg;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// ============================================================================
//  Module      : tb_mem_access_unit
//  Description : Self-checking bench for mem_access_unit. It holds a RAM
//                model and a reference memory. Expected writes go into a
//                scoreboard queue, and a monitor pops that queue.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access_unit;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_STORE = 2'b01;
  localparam logic [1:0] OP_FILL  = 2'b10;
  localparam logic [1:0] OP_COPY  = 2'b11;

  typedef struct {
    logic [7:0]  a;
    logic [15:0] d;
  } wr_t;

  logic clk = 1'b0;
  logic reset;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] mem     [0:255];
  logic [15:0] ref_mem [0:255];
  logic [15:0] last_rd;
  wr_t         sb[$];

  mem_access_unit_if #(.ADDR_W(8), .DATA_W(16)) bus ();

  mem_access_unit #(.ADDR_W(8), .DATA_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // RAM model: combinational read, write committed at posedge
  assign bus.ram_rdata = bus.ram_re ? mem[bus.ram_addr] : 16'h0000;

  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
  end

  // Write monitor: every write strobe must match the next scoreboard entry
  always @(negedge clk) begin
    if (bus.ram_we && bus.ram_re) begin
      n_err++;
      $display("FAIL we_re_overlap: both strobes high at addr %h", bus.ram_addr);
    end
    if (bus.ram_we) begin
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_write: addr %h data %h, none expected",
                 bus.ram_addr, bus.ram_wdata);
      end else begin
        wr_t w;
        w = sb.pop_front();
        n_cmp++;
        if ({bus.ram_addr, bus.ram_wdata} !== {w.a, w.d}) begin
          n_err++;
          $display("FAIL write: got addr %h data %h, want addr %h data %h",
                   bus.ram_addr, bus.ram_wdata, w.a, w.d);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Issue one command, predict its effects from ref_mem and check each cycle.
  task automatic run_cmd(input logic [1:0] op, input logic [7:0] addr,
                         input logic [7:0] src, input logic [7:0] len,
                         input logic [15:0] wd);
    int          k;
    int          bad;
    logic        exp_wrap;
    logic        e_we, e_re;
    logic [7:0]  e_addr;
    logic [7:0]  a;
    logic [15:0] d;
    bad = 0;
    exp_wrap = 1'b0;
    case (op)
      OP_LOAD: begin
        k = 2;
        last_rd = ref_mem[addr];
      end
      OP_STORE: begin
        k = 2;
        sb.push_back('{addr, wd});
        ref_mem[addr] = wd;
      end
      OP_FILL: begin
        k = (len == 0) ? 1 : int'(len) + 1;
        for (int i = 0; i < int'(len); i++) begin
          a = addr + 8'(i);
          sb.push_back('{a, wd});
          ref_mem[a] = wd;
        end
        exp_wrap = (len != 0) && (int'(addr) + int'(len) - 1 > 255);
      end
      default: begin
        k = (len == 0) ? 1 : 2 * int'(len) + 1;
        for (int i = 0; i < int'(len); i++) begin
          d = ref_mem[src + 8'(i)];
          a = addr + 8'(i);
          sb.push_back('{a, d});
          ref_mem[a] = d;
        end
        exp_wrap = (len != 0) && ((int'(addr) + int'(len) - 1 > 255) ||
                                  (int'(src) + int'(len) - 1 > 255));
      end
    endcase

    @(negedge clk);
    n_cmp++;
    if (bus.cmd_ready !== 1'b1) begin
      n_err++;
      $display("FAIL ready_before_cmd: got %b want 1", bus.cmd_ready);
    end
    bus.cmd_op    = op;
    bus.cmd_addr  = addr;
    bus.cmd_src   = src;
    bus.cmd_len   = len;
    bus.cmd_wdata = wd;
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    // Scramble the fields so that any late sampling shows up.
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'($urandom);
    bus.cmd_addr  = 8'($urandom);
    bus.cmd_src   = 8'($urandom);
    bus.cmd_len   = 8'($urandom);
    bus.cmd_wdata = 16'($urandom);

    for (int i = 1; i <= k; i++) begin
      @(negedge clk);
      if (i < k) begin
        case (op)
          OP_LOAD:  begin e_we = 1'b0; e_re = 1'b1; e_addr = addr; end
          OP_STORE: begin e_we = 1'b1; e_re = 1'b0; e_addr = addr; end
          OP_FILL:  begin e_we = 1'b1; e_re = 1'b0; e_addr = addr + 8'(i - 1); end
          default: begin
            e_we   = (i % 2 == 0);
            e_re   = (i % 2 == 1);
            e_addr = (i % 2 == 1) ? src + 8'((i - 1) / 2) : addr + 8'(i / 2 - 1);
          end
        endcase
        if ({bus.done, bus.cmd_ready, bus.ram_we, bus.ram_re, bus.ram_addr} !==
            {1'b0, 1'b0, e_we, e_re, e_addr}) begin
          bad++;
          $display("FAIL cycle_%0d op %0d: got done %b rdy %b we %b re %b addr %h, want 0 0 %b %b %h",
                   i, op, bus.done, bus.cmd_ready, bus.ram_we, bus.ram_re,
                   bus.ram_addr, e_we, e_re, e_addr);
        end
      end else begin
        n_cmp++;
        if (bus.done !== 1'b1) begin
          n_err++;
          $display("FAIL done_at_%0d op %0d: got %b want 1", k, op, bus.done);
        end
        n_cmp++;
        if (bus.wrap_err !== exp_wrap) begin
          n_err++;
          $display("FAIL wrap_err op %0d: got %b want %b", op, bus.wrap_err, exp_wrap);
        end
        n_cmp++;
        if (bus.rd_data !== last_rd) begin
          n_err++;
          $display("FAIL rd_data op %0d: got %h want %h", op, bus.rd_data, last_rd);
        end
        n_cmp++;
        if ({bus.ram_we, bus.ram_re, bus.ram_addr, bus.ram_wdata} !== 26'd0) begin
          n_err++;
          $display("FAIL ram_idle_in_done: got we %b re %b addr %h wdata %h want zeros",
                   bus.ram_we, bus.ram_re, bus.ram_addr, bus.ram_wdata);
        end
      end
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL bus_pattern op %0d: got %0d bad cycles want 0", op, bad);
    end

    @(negedge clk);
    n_cmp++;
    if ({bus.done, bus.wrap_err, bus.cmd_ready} !== 3'b001) begin
      n_err++;
      $display("FAIL after_done: got done %b wrap %b rdy %b want 0 0 1",
               bus.done, bus.wrap_err, bus.cmd_ready);
    end
    n_cmp++;
    if (sb.size() !== 0) begin
      n_err++;
      $display("FAIL sb_drain: got %0d pending writes want 0", sb.size());
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    n_cmp++;
    if ({bus.cmd_ready, bus.done, bus.wrap_err, bus.rd_data,
         bus.ram_we, bus.ram_re, bus.ram_addr, bus.ram_wdata} !==
        {1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 8'h0, 16'h0}) begin
      n_err++;
      $display("FAIL %s: got rdy %b done %b wrap %b rd %h we %b re %b addr %h wd %h, want 1 0 0 0 0 0 0 0",
               tag, bus.cmd_ready, bus.done, bus.wrap_err, bus.rd_data,
               bus.ram_we, bus.ram_re, bus.ram_addr, bus.ram_wdata);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.cmd_valid = 1'b1;  // must be ignored while reset is held
    bus.cmd_op    = OP_STORE;
    bus.cmd_addr  = 8'h77;
    bus.cmd_wdata = 16'hDEAD;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_values");
    reset = 1'b0;
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.done, bus.cmd_ready, bus.ram_we} !== 3'b010) begin
      n_err++;
      $display("FAIL no_accept_in_reset: got done %b rdy %b we %b want 0 1 0",
               bus.done, bus.cmd_ready, bus.ram_we);
    end
  endtask

  task automatic test_store_load;
    run_cmd(OP_STORE, 8'h10, 8'h00, 8'd0, 16'hBEEF);
    run_cmd(OP_LOAD,  8'h10, 8'h00, 8'd0, 16'h0000);
    run_cmd(OP_STORE, 8'h11, 8'h00, 8'd0, 16'h4321);  // rd_data must hold
    run_cmd(OP_LOAD,  8'h05, 8'h00, 8'd0, 16'h0000);
  endtask

  task automatic test_fill_copy;
    run_cmd(OP_FILL, 8'h20, 8'h00, 8'd4, 16'h1234);
    run_cmd(OP_COPY, 8'h40, 8'h20, 8'd3, 16'h0000);
    n_cmp++;
    if ({mem[8'h40], mem[8'h41], mem[8'h42]} !== {3{16'h1234}}) begin
      n_err++;
      $display("FAIL copy_dest: got %h %h %h want 1234 x3", mem[8'h40], mem[8'h41], mem[8'h42]);
    end
    run_cmd(OP_COPY, 8'h21, 8'h1F, 8'd4, 16'h0000);  // overlapping, ascending
  endtask

  task automatic test_wrap;
    run_cmd(OP_FILL, 8'hFE, 8'h00, 8'd3, 16'hAAAA);
    run_cmd(OP_FILL, 8'hFD, 8'h00, 8'd3, 16'h5555);  // ends exactly at 0xFF
    run_cmd(OP_COPY, 8'h80, 8'hFF, 8'd2, 16'h0000);  // source wraps
    run_cmd(OP_COPY, 8'hFF, 8'h60, 8'd2, 16'h0000);  // destination wraps
    run_cmd(OP_COPY, 8'h90, 8'hFE, 8'd2, 16'h0000);  // no wrap
  endtask

  task automatic test_zero_len;
    logic [1:0] exp_dr [0:3];
    run_cmd(OP_FILL, 8'h30, 8'h00, 8'd0, 16'h7777);
    run_cmd(OP_COPY, 8'h30, 8'h31, 8'd0, 16'h0000);
    // valid held high through DONE: the second accept happens only in IDLE
    exp_dr[0] = 2'b10; exp_dr[1] = 2'b01; exp_dr[2] = 2'b10; exp_dr[3] = 2'b01;
    @(negedge clk);
    bus.cmd_op    = OP_FILL;
    bus.cmd_addr  = 8'h30;
    bus.cmd_len   = 8'd0;
    bus.cmd_wdata = 16'h7777;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 2) bus.cmd_valid = 1'b0;
      n_cmp++;
      if ({bus.done, bus.cmd_ready} !== exp_dr[i]) begin
        n_err++;
        $display("FAIL held_valid_%0d: got done,rdy %b%b want %b", i,
                 bus.done, bus.cmd_ready, exp_dr[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    for (int n = 0; n < 24; n++) begin
      run_cmd(2'($urandom), 8'($urandom), 8'($urandom),
              8'($urandom_range(0, 6)), 16'($urandom));
    end
  endtask

  task automatic test_reset_mid;
    int diffs;
    sb.push_back('{8'h50, 16'h6543});
    sb.push_back('{8'h51, 16'h6543});
    sb.push_back('{8'h52, 16'h6543});  // strobed but must not commit
    ref_mem[8'h50] = 16'h6543;
    ref_mem[8'h51] = 16'h6543;
    @(negedge clk);
    bus.cmd_op    = OP_FILL;
    bus.cmd_addr  = 8'h50;
    bus.cmd_len   = 8'd8;
    bus.cmd_wdata = 16'h6543;
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1 check_reset_outputs("async_reset");
    last_rd = 16'h0000;
    bus.cmd_valid = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    bus.cmd_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.done, bus.cmd_ready, bus.ram_we} !== 3'b010) begin
        n_err++;
        $display("FAIL after_abort: got done %b rdy %b we %b want 0 1 0",
                 bus.done, bus.cmd_ready, bus.ram_we);
      end
    end
    n_cmp++;
    if (sb.size() !== 0) begin
      n_err++;
      $display("FAIL abort_writes: got %0d pending want 0", sb.size());
    end
    diffs = 0;
    for (int i = 8'h50; i <= 8'h57; i++) if (mem[i] !== ref_mem[i]) diffs++;
    n_cmp++;
    if (diffs != 0) begin
      n_err++;
      $display("FAIL abort_mem: got %0d differing words in 0x50-0x57 want 0", diffs);
    end
  endtask

  initial begin
    int diffs;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 16'(i * 16'h0101) ^ 16'h5A5A;
      ref_mem[i] = 16'(i * 16'h0101) ^ 16'h5A5A;
    end
    last_rd       = 16'h0000;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_addr  = 8'h00;
    bus.cmd_src   = 8'h00;
    bus.cmd_len   = 8'h00;
    bus.cmd_wdata = 16'h0000;

    test_reset();
    test_store_load();
    test_fill_copy();
    test_wrap();
    test_zero_len();
    test_back_to_back();
    test_reset_mid();

    diffs = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) diffs++;
    n_cmp++;
    if (diffs != 0) begin
      n_err++;
      $display("FAIL final_mem: got %0d differing words want 0", diffs);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter ADDR_W, default 8, RAM address width; 256 word locations.
REQ-002 Parameter DATA_W, default 16, RAM word width.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-005 cmd_valid  input  1  command request from control unit.
REQ-006 cmd_ready  output  1  high only in IDLE; command accepted on posedge when cmd_valid && cmd_ready.
REQ-007 cmd_op  input  2  00 LOAD, 01 STORE, 10 FILL, 11 COPY.
REQ-008 cmd_addr  input  ADDR_W  LOAD/STORE address; FILL/COPY destination start.
REQ-009 cmd_src  input  ADDR_W  COPY source start; ignored otherwise.
REQ-010 cmd_len  input  8  FILL/COPY word count; ignored for LOAD/STORE.
REQ-011 cmd_wdata  input  DATA_W  STORE data / FILL value.
REQ-012 done  output  1  one-cycle pulse at command completion.
REQ-013 rd_data  output  DATA_W  last LOAD result; holds until next LOAD completes.
REQ-014 wrap_err  output  1  valid with done; address wrapped past 0xFF during the command.
REQ-015 ram_we  output  1  RAM write enable; write committed at posedge.
REQ-016 ram_re  output  1  RAM read enable; RAM returns combinational data in the same cycle.
REQ-017 ram_addr  output  ADDR_W  RAM access address.
REQ-018 ram_wdata  output  DATA_W  RAM write data.
REQ-019 ram_rdata  input  DATA_W  RAM read data; zero when ram_re low.

Function
REQ-020 States: IDLE, LD_RD, ST_WR, FILL_WR, CP_RD, CP_WR, DONE.
REQ-021 All outputs registered; in IDLE and DONE: ram_we=0, ram_re=0, ram_addr=0, ram_wdata=0.
REQ-022 ram_we and ram_re never both high in any cycle.
REQ-023 Command fields latched at acceptance; input changes afterwards have no effect.
REQ-024 LOAD accepted cycle N: LD_RD in N+1 (ram_re=1, ram_addr=cmd_addr), rd_data<=ram_rdata at end of N+1, done in N+2.
REQ-025 STORE accepted cycle N: ST_WR in N+1 (ram_we=1, ram_addr=cmd_addr, ram_wdata=cmd_wdata), done in N+2.
REQ-026 FILL len L>0: FILL_WR cycles N+1..N+L, one write per cycle, ascending addresses from cmd_addr, all data cmd_wdata; done in N+L+1.
REQ-027 COPY len L>0: per word CP_RD (ram_re=1, ram_addr=src) then CP_WR (ram_we=1, ram_addr=dst, ram_wdata=captured word); ascending order, source then destination incremented; done in N+2L+1.
REQ-028 COPY with overlapping ranges executes strictly word-by-word ascending; no overlap correction.
REQ-029 cmd_len=0 for FILL/COPY: no RAM access, DONE in N+1, wrap_err=0.
REQ-030 Address arithmetic modulo 2^ADDR_W; wrap_err=1 when any address increments 0xFF->0x00 within the command (start+L-1 > 255 on source or destination); operation still completes.
REQ-031 DONE lasts exactly one cycle, then IDLE; cmd_ready returns high the cycle after done.
REQ-032 wrap_err valid only while done=1; 0 otherwise.
REQ-033 LOAD/STORE never assert wrap_err.

Reset
REQ-034 reset asserted: state IDLE, cmd_ready=1, done=0, wrap_err=0, rd_data=0, ram_we=0, ram_re=0, ram_addr=0, ram_wdata=0, asynchronously.
REQ-035 reset mid-command aborts it with no done; writes committed before reset remain in RAM; no further writes issued.
REQ-036 Command presented during reset or on the release edge is not accepted.

Verification
REQ-037 STORE addr 0x10 data 0xBEEF, then LOAD 0x10 -> one ram_we cycle, done at N+2; LOAD rd_data=0xBEEF at N+2.
REQ-038 FILL addr 0x20 len 4 value 0x1234 -> ram_we high 4 consecutive cycles, addrs 0x20-0x23, done at N+5, wrap_err=0.
REQ-039 COPY src 0x20 dst 0x40 len 3 after REQ-038 -> alternating re/we, 0x40-0x42 = 0x1234, done at N+7.
REQ-040 FILL addr 0xFE len 3 value 0xAAAA -> writes 0xFE, 0xFF, 0x00; done with wrap_err=1.
REQ-041 FILL len 0 -> no ram_we, done at N+1, wrap_err=0; cmd_valid held high in DONE not accepted until IDLE.
REQ-042 reset asserted during 3rd write of FILL len 8 at 0x50 -> 0x50-0x51 written, 0x52-0x57 unchanged, no done, all outputs at reset values.
